// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: FSM state encoding and default word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fixed_point_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift remainder left, trial-subtract divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
    parameter int W = 15
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem_i, 1'b0};
        diff    = shifted - {1'b0, div_i};
        q_o     = 1'b0;
        rem_o   = shifted[W-1:0];
        // Remainder stays below the divisor, so the restored value fits W bits.
        if (shifted >= {1'b0, div_i}) begin
            q_o   = 1'b1;
            rem_o = diff[W-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sign-magnitude fixed-point divider (Q0.N-1), restoring, one quotient bit per cycle.
// Latency: start edge to done is N cycles, N+1 with DIVIDER_ROUND_EN (round half-up).
// Backpressure: start is ignored while busy; one division in flight at a time.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] w,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         dbz
);

    localparam int M = N - 1;
`ifdef DIVIDER_ROUND_EN
    localparam int ITERS = N;
`else
    localparam int ITERS = N - 1;
`endif
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [M-1:0]     rem_q, rem_d;
    logic [M-1:0]     div_q, div_d;
    logic [ITERS-1:0] quo_q, quo_d;
    logic             sign_q, sign_d;
    logic             ovf_pre_q, ovf_pre_d;
    logic             dbz_pre_q, dbz_pre_d;
    logic [N-1:0]     out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [M-1:0]     step_rem;
    logic             step_q;
    logic [M-1:0]     mag_raw;
    logic [M-1:0]     mag_fin;
    logic             carry;
    logic             ovf_fin;

    div_step #(.W(M)) u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

`ifdef DIVIDER_ROUND_EN
    logic [M:0] rnd_sum;

    always_comb begin
        rnd_sum = {1'b0, quo_q[ITERS-1:1]} + {{M{1'b0}}, quo_q[0]};
        carry   = rnd_sum[M];
        mag_raw = rnd_sum[M-1:0];
    end
`else
    always_comb begin
        carry   = 1'b0;
        mag_raw = quo_q;
    end
`endif

    // Saturation flags were captured at latch time; divide-by-zero wins over overflow.
    always_comb begin
        mag_fin = mag_raw;
        ovf_fin = 1'b0;
        if (dbz_pre_q) begin
            mag_fin = '1;
        end else if (ovf_pre_q || carry) begin
            mag_fin = '1;
            ovf_fin = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        div_d     = div_q;
        quo_d     = quo_q;
        sign_d    = sign_q;
        ovf_pre_d = ovf_pre_q;
        dbz_pre_d = dbz_pre_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    rem_d     = a[M-1:0];
                    div_d     = w[M-1:0];
                    quo_d     = '0;
                    sign_d    = a[N-1] ^ w[N-1];
                    dbz_pre_d = (w[M-1:0] == '0);
                    ovf_pre_d = (w[M-1:0] != '0) && (a[M-1:0] >= w[M-1:0]);
                end
            end
            CALC: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    out_d   = {sign_q, mag_fin};
                    ovf_d   = ovf_fin;
                    dbz_d   = dbz_pre_q;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[ITERS-2:0], step_q};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            sign_q    <= 1'b0;
            ovf_pre_q <= 1'b0;
            dbz_pre_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            sign_q    <= sign_d;
            ovf_pre_q <= ovf_pre_d;
            dbz_pre_q <= dbz_pre_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 Parameter: N, default 16, total word width; bit N-1 is the sign and bits N-2:0 are the magnitude, with N-1 fractional bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  N  dividend, sign-magnitude fixed point.
REQ-006 w  input  N  divisor, sign-magnitude fixed point.
REQ-007 out  output  N  quotient a/w, sign-magnitude fixed point.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse when out is valid.
REQ-010 ovf  output  1  result magnitude would be >= 1.0; valid with done.
REQ-011 dbz  output  1  divisor magnitude is zero; valid with done.

Function
REQ-012 FSM states IDLE, CALC, DONE; the block SHALL reset to IDLE.
REQ-013 IDLE: start=1 at an edge latches a and w, clears the iteration counter, and moves to CALC.
REQ-014 CALC: restoring division, one quotient bit per cycle, MSB first, on (|a| << (N-1)) / |w|; runs exactly N-1 iterations, then moves to DONE.
REQ-015 DONE: done=1 for exactly one cycle, out/ovf/dbz updated that cycle, then back to IDLE.
REQ-016 Fixed latency: start sampled at edge t gives busy=1 from t+1 and done=1 in the cycle after edge t+N; a new start is accepted in the cycle after done.
REQ-017 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-018 start while busy SHALL be ignored; a and w are not re-sampled.
REQ-019 Sign: out[N-1] = a[N-1] XOR w[N-1], including zero and saturated results.
REQ-020 Magnitude truncates toward zero; the remainder is discarded.
REQ-021 |a| >= |w| with |w| != 0: magnitude saturates to all ones and ovf=1.
REQ-022 |w| == 0 (either sign): magnitude saturates to all ones and dbz=1; ovf=0, and dbz takes priority.
REQ-023 Latency is unchanged by ovf and dbz; they are detected at latch time and override the result in DONE.
REQ-024 out, ovf and dbz SHALL hold their values until the next DONE.

Reset
REQ-025 rst=0 forces at once, in any state, state=IDLE, out=0, busy=0, done=0, ovf=0, dbz=0, and counter and working registers to 0.
REQ-026 Reset during CALC aborts the operation with no done pulse; the first start after reset release SHALL be served normally.

Configuration
REQ-027 Macro DIVIDER_ROUND_EN defined: CALC computes one extra guard bit (N iterations) and rounds half-up on magnitude. Latency becomes N+1. A round carry into the sign position SHALL saturate and set ovf.
REQ-028 Macro DIVIDER_ROUND_EN undefined: truncation per REQ-020, with latency N.

Structure
REQ-029 Shared package fixed_point_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default-width constant; the Multiplier and this block import it.
REQ-030 Sub-module div_step: combinational single restoring step, taking partial remainder and divisor and giving the next remainder and quotient bit; instantiated once and reused each cycle.

Verification (N=8, rounding off unless stated)
REQ-031 a=0x20 (0.25), w=0x40 (0.5) -> after 8 cycles done=1, out=0x40, ovf=0, dbz=0.
REQ-032 a=0xA0 (-0.25), w=0x40 -> out=0xC0; with a=0xA0, w=0xC0 -> out=0x40.
REQ-033 a=0x40, w=0x20 -> out=0x7F, ovf=1; a=0x40, w=0x40 -> out=0x7F, ovf=1.
REQ-034 a=0x10, w=0x80 (negative zero) -> out=0xFF, dbz=1, ovf=0, latency still 8.
REQ-035 a=0x01, w=0x03 -> out=0x2A; with DIVIDER_ROUND_EN -> out=0x2B after 9 cycles.
REQ-036 start pulsed again mid-CALC is ignored, with a single done; rst=0 during CALC gives no done and all outputs 0, and the next start with a=0x20, w=0x40 gives out=0x40.
